// File: rtl/i2c_spi_sched_pkg.sv
// Shared types for the I2C/local-poll Wishbone scheduler: FSM states and
// the 2-bit completion status codes returned to each requester.
package i2c_spi_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUS     = 2'd1,
      BACKOFF = 2'd2,
      DONE    = 2'd3
   } sched_state_t;

   typedef logic [1:0] sts_t;

   localparam sts_t STS_OK  = 2'b00;
   localparam sts_t STS_ERR = 2'b01;
   localparam sts_t STS_RTY = 2'b10;
   localparam sts_t STS_TMO = 2'b11;

endpackage

// File: rtl/i2c_spi_rr_arbiter.sv
// Two-way round-robin arbiter. On a tie the requester that was NOT granted
// last time wins; a lone request is always granted.
module i2c_spi_rr_arbiter (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant,
   output logic       valid
);

   // Grant selection: tie goes to the opposite of the last grant
   always_comb begin
      valid = |req;
      grant = 1'b0;
      if (req == 2'b11) begin
         grant = ~last;
      end else if (req[1]) begin
         grant = 1'b1;
      end
   end

endmodule

// File: rtl/i2c_spi_wb_scheduler.sv
// Wishbone master shared by two requesters (0 = I2C command path,
// 1 = local status/poll path). One Wishbone cycle per grant, retry on rty,
// abort on err or timeout, per-requester done/status/read-data.
// Optional feature macro: I2C_SPI_SCHED_STATS_EN adds saturating error and
// retry counters (stat_err_o, stat_rty_o).
module i2c_spi_wb_scheduler
   import i2c_spi_sched_pkg::*;
#(
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = 8,
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 15
) (
   input  logic              i2c_wb_clk_i,
   input  logic              i2c_wb_rst_i,
   input  logic              r0_req_i,
   input  logic              r0_we_i,
   input  logic [ADDR_W-1:0] r0_adr_i,
   input  logic [DATA_W-1:0] r0_dat_i,
   output logic              r0_done_o,
   output logic [1:0]        r0_sts_o,
   output logic [DATA_W-1:0] r0_dat_o,
   input  logic              r1_req_i,
   input  logic              r1_we_i,
   input  logic [ADDR_W-1:0] r1_adr_i,
   input  logic [DATA_W-1:0] r1_dat_i,
   output logic              r1_done_o,
   output logic [1:0]        r1_sts_o,
   output logic [DATA_W-1:0] r1_dat_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [DATA_W-1:0] wb_dat_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i,
   input  logic              wb_rty_i
`ifdef I2C_SPI_SCHED_STATS_EN
   ,
   output logic [7:0]        stat_err_o,
   output logic [7:0]        stat_rty_o
`endif
);

   // Retry counter never exceeds MAX_RETRY; timeout counter never exceeds TIMEOUT-1
   localparam int RTY_W = $clog2(MAX_RETRY + 2);
   localparam int TMO_W = $clog2(TIMEOUT);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   sched_state_t      state_q, state_d;
   sts_t              done_sts;
   logic              gnt_q, last_q;
   logic              we_q;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] dat_q;
   logic [RTY_W-1:0]  retry_q;
   logic [TMO_W-1:0]  tmo_q;
   sts_t              r0_sts_q, r1_sts_q;
   logic [DATA_W-1:0] r0_dat_q, r1_dat_q;
   logic              arb_grant, arb_valid;

   i2c_spi_rr_arbiter u_arb (
      .req   ({r1_req_i, r0_req_i}),
      .last  (last_q),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   // State register; async reset drops cyc/stb immediately via state decode
   always_ff @(posedge i2c_wb_clk_i or negedge i2c_wb_rst_i) begin
      if (!i2c_wb_rst_i) state_q <= IDLE;
      else               state_q <= state_d;
   end

   // Next state and completion status; response priority ack > err > rty > timeout
   always_comb begin
      state_d  = state_q;
      done_sts = STS_OK;
      case (state_q)
         IDLE: begin
            if (arb_valid) state_d = BUS;
         end
         BUS: begin
            if (wb_ack_i) begin
               state_d  = DONE;
               done_sts = STS_OK;
            end else if (wb_err_i) begin
               state_d  = DONE;
               done_sts = STS_ERR;
            end else if (wb_rty_i) begin
               if (retry_q < RTY_MAX) begin
                  state_d = BACKOFF;
               end else begin
                  state_d  = DONE;
                  done_sts = STS_RTY;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d  = DONE;
               done_sts = STS_TMO;
            end
         end
         BACKOFF: state_d = BUS;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus strobes and the done pulse for the granted requester only
   always_comb begin
      wb_cyc_o  = (state_q == BUS);
      wb_stb_o  = (state_q == BUS);
      r0_done_o = (state_q == DONE) && !gnt_q;
      r1_done_o = (state_q == DONE) &&  gnt_q;
   end

   assign wb_we_o  = we_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign r0_sts_o = r0_sts_q;
   assign r1_sts_o = r1_sts_q;
   assign r0_dat_o = r0_dat_q;
   assign r1_dat_o = r1_dat_q;

   // Request capture, retry/timeout counting and per-requester result latching
   always_ff @(posedge i2c_wb_clk_i or negedge i2c_wb_rst_i) begin
      if (!i2c_wb_rst_i) begin
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         retry_q  <= '0;
         tmo_q    <= '0;
         r0_sts_q <= STS_OK;
         r1_sts_q <= STS_OK;
         r0_dat_q <= '0;
         r1_dat_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  gnt_q   <= arb_grant;
                  we_q    <= arb_grant ? r1_we_i  : r0_we_i;
                  adr_q   <= arb_grant ? r1_adr_i : r0_adr_i;
                  dat_q   <= arb_grant ? r1_dat_i : r0_dat_i;
                  retry_q <= '0;
                  tmo_q   <= '0;
               end
            end
            BUS: begin
               if (state_d == BACKOFF) begin
                  retry_q <= retry_q + RTY_W'(1);
                  tmo_q   <= '0;
               end else if (state_d == BUS) begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end else begin
                  tmo_q <= '0;
                  if (!gnt_q) begin
                     r0_sts_q <= done_sts;
                     if (done_sts == STS_OK && !we_q) r0_dat_q <= wb_dat_i;
                  end else begin
                     r1_sts_q <= done_sts;
                     if (done_sts == STS_OK && !we_q) r1_dat_q <= wb_dat_i;
                  end
               end
            end
            DONE: begin
               last_q  <= gnt_q;
               retry_q <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef I2C_SPI_SCHED_STATS_EN
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [7:0] stat_err_q, stat_rty_q;

   // Saturating counters: failed completions and accepted retries
   always_ff @(posedge i2c_wb_clk_i or negedge i2c_wb_rst_i) begin
      if (!i2c_wb_rst_i) begin
         stat_err_q <= 8'd0;
         stat_rty_q <= 8'd0;
      end else begin
         if (state_q == BUS && wb_rty_i && !wb_ack_i && !wb_err_i)
            stat_rty_q <= sat_inc(stat_rty_q);
         if (state_q == BUS && state_d == DONE && done_sts != STS_OK)
            stat_err_q <= sat_inc(stat_err_q);
      end
   end

   assign stat_err_o = stat_err_q;
   assign stat_rty_o = stat_rty_q;
`endif

endmodule

// File: tb/tb_i2c_spi_wb_scheduler.sv
// Self-checking bench for i2c_spi_wb_scheduler (default parameters).
// Define I2C_SPI_SCHED_STATS_EN to also exercise the statistics counters.
module tb_i2c_spi_wb_scheduler;
   import i2c_spi_sched_pkg::*;

   localparam logic [2:0] C_NONE = 3'd0, C_ACK = 3'd1, C_ERR = 3'd2,
                          C_RTY = 3'd3, C_AE = 3'd4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
   logic [2:0] r0_adr = 0, r1_adr = 0;
   logic [7:0] r0_dat = 0, r1_dat = 0;
   logic       r0_done_o, r1_done_o;
   logic [1:0] r0_sts_o, r1_sts_o;
   logic [7:0] r0_dat_o, r1_dat_o;
   logic       wb_cyc_o, wb_stb_o, wb_we_o;
   logic [2:0] wb_adr_o;
   logic [7:0] wb_dat_o;
   logic [7:0] wb_dat_i = 0;
   logic       wb_ack_i = 0, wb_err_i = 0, wb_rty_i = 0;
`ifdef I2C_SPI_SCHED_STATS_EN
   logic [7:0] stat_err_o, stat_rty_o;
`endif

   i2c_spi_wb_scheduler dut (
      .i2c_wb_clk_i (clk),
      .i2c_wb_rst_i (rst_n),
      .r0_req_i     (r0_req),
      .r0_we_i      (r0_we),
      .r0_adr_i     (r0_adr),
      .r0_dat_i     (r0_dat),
      .r0_done_o    (r0_done_o),
      .r0_sts_o     (r0_sts_o),
      .r0_dat_o     (r0_dat_o),
      .r1_req_i     (r1_req),
      .r1_we_i      (r1_we),
      .r1_adr_i     (r1_adr),
      .r1_dat_i     (r1_dat),
      .r1_done_o    (r1_done_o),
      .r1_sts_o     (r1_sts_o),
      .r1_dat_o     (r1_dat_o),
      .wb_cyc_o     (wb_cyc_o),
      .wb_stb_o     (wb_stb_o),
      .wb_we_o      (wb_we_o),
      .wb_adr_o     (wb_adr_o),
      .wb_dat_o     (wb_dat_o),
      .wb_dat_i     (wb_dat_i),
      .wb_ack_i     (wb_ack_i),
      .wb_err_i     (wb_err_i),
      .wb_rty_i     (wb_rty_i)
`ifdef I2C_SPI_SCHED_STATS_EN
      ,
      .stat_err_o   (stat_err_o),
      .stat_rty_o   (stat_rty_o)
`endif
   );

   typedef struct packed { logic [2:0] code; logic [7:0] data; } resp_t;
   typedef struct packed { logic rq; logic [1:0] sts; logic [7:0] dat; logic upd; } sb_t;
   typedef struct packed {
      logic        rq;
      logic        we;
      logic [2:0]  adr;
      logic [7:0]  dat;
      logic [3:0]  nresp;
      logic [17:0] codes;   // response code k at bits [3k+2:3k]
      logic [7:0]  rdat;
      logic [1:0]  sts;
      logic [3:0]  gaps;
      logic [7:0]  lat;     // cycles from req cycle to done cycle, inclusive
   } vec_t;

   resp_t resp_q[$];
   sb_t   sb[$];
   int    n_tests = 0, n_fail = 0;
   logic [1:0] mdl_sts [2];
   logic [7:0] mdl_dat [2];

   logic       stab_en = 0;
   logic [2:0] cur_adr = 0;
   logic [7:0] cur_dat = 0;
   logic       cur_we = 0;
   int         segs = 0, gap_bad = 0, stab_bad = 0, low_run = 0;
   logic       cyc_prev = 0, done_prev = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [17:0] codes4(input logic [2:0] a, b, c, d);
      return {6'd0, d, c, b, a};
   endfunction

   // Wishbone slave: one scripted response per BUS cycle, plus bus-shape monitoring
   always @(negedge clk) begin
      resp_t r;
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
      if (wb_cyc_o) begin
         if (stab_en && (wb_adr_o !== cur_adr || wb_dat_o !== cur_dat ||
                         wb_we_o !== cur_we || wb_stb_o !== 1'b1)) stab_bad++;
         if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            wb_dat_i = r.data;
            case (r.code)
               C_ACK:   wb_ack_i = 1;
               C_ERR:   wb_err_i = 1;
               C_RTY:   wb_rty_i = 1;
               C_AE:    begin wb_ack_i = 1; wb_err_i = 1; end
               default: ;
            endcase
         end
         if (!cyc_prev) begin
            if (segs > 0 && low_run != 1) gap_bad++;
            segs++;
         end
         low_run = 0;
      end else begin
         low_run++;
      end
      cyc_prev = wb_cyc_o;
   end

   // Scoreboard: each done pulse pops the oldest expected completion
   always @(negedge clk) begin
      sb_t e;
      logic rq;
      logic [7:0] exp_dat;
      if (r0_done_o || r1_done_o) begin
         chk("done one-hot", {31'd0, r0_done_o & r1_done_o}, 0);
         chk("done pulse width", {31'd0, done_prev}, 0);
         rq = r1_done_o;
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected done: got requester %0d, expected none", rq);
         end else begin
            e = sb.pop_front();
            exp_dat = e.upd ? e.dat : mdl_dat[rq];
            chk("done requester", {31'd0, rq}, {31'd0, e.rq});
            chk("status", rq ? r1_sts_o : r0_sts_o, e.sts);
            chk("read data", rq ? r1_dat_o : r0_dat_o, exp_dat);
            chk("other sts held", rq ? r0_sts_o : r1_sts_o, mdl_sts[!rq]);
            chk("other dat held", rq ? r0_dat_o : r1_dat_o, mdl_dat[!rq]);
            mdl_sts[rq] = e.sts;
            mdl_dat[rq] = exp_dat;
         end
      end
      done_prev = r0_done_o || r1_done_o;
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      r0_req = 0; r1_req = 0;
      resp_q.delete(); sb.delete();
      mdl_sts[0] = 0; mdl_sts[1] = 0; mdl_dat[0] = 0; mdl_dat[1] = 0;
      repeat (2) @(negedge clk);
      chk("reset ctl", {27'd0, wb_cyc_o, wb_stb_o, wb_we_o, r0_done_o, r1_done_o}, 0);
      chk("reset sts", {28'd0, r0_sts_o, r1_sts_o}, 0);
      chk("reset rdat", {16'd0, r0_dat_o, r1_dat_o}, 0);
      chk("reset bus", {21'd0, wb_adr_o, wb_dat_o}, 0);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int  edges;
      bit  got;
      for (int k = 0; k < int'(v.nresp); k++)
         resp_q.push_back('{code: v.codes[3*k +: 3], data: v.rdat});
      sb.push_back('{rq: v.rq, sts: v.sts, dat: v.rdat, upd: (v.sts == STS_OK && !v.we)});
      cur_adr = v.adr; cur_dat = v.dat; cur_we = v.we; stab_en = 1;
      segs = 0; gap_bad = 0; stab_bad = 0;
      @(posedge clk); #1;
      if (v.rq) begin r1_req = 1; r1_we = v.we; r1_adr = v.adr; r1_dat = v.dat; end
      else      begin r0_req = 1; r0_we = v.we; r0_adr = v.adr; r0_dat = v.dat; end
      edges = 0; got = 0;
      while (!got && edges < 100) begin
         @(posedge clk); edges++;
         @(negedge clk);
         if (v.rq ? r1_done_o : r0_done_o) got = 1;
      end
      r0_req = 0; r1_req = 0;
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL %s done: got no done in 100 cycles, expected done", nm);
      end else begin
         chk({nm, " latency"}, edges + 1, v.lat);
         chk({nm, " cyc gaps"}, segs - 1, v.gaps);
         chk({nm, " gap width"}, gap_bad, 0);
         chk({nm, " bus stable"}, stab_bad, 0);
      end
      resp_q.delete();
      stab_en = 0;
   endtask

   vec_t vt [8];

   initial begin
      int n;
      bit got;
      // rq we adr dat nresp codes rdat sts gaps lat
      vt[0] = '{0, 1, 3'd3, 8'hA5, 4'd1, codes4(C_ACK, 0, 0, 0),           8'h00, STS_OK,  4'd0, 8'd3};
      vt[1] = '{1, 0, 3'd5, 8'h00, 4'd4, codes4(C_RTY, C_RTY, C_RTY, C_ACK), 8'h5A, STS_OK,  4'd3, 8'd9};
      vt[2] = '{0, 1, 3'd2, 8'h0F, 4'd4, codes4(C_RTY, C_RTY, C_RTY, C_RTY), 8'h00, STS_RTY, 4'd3, 8'd9};
      vt[3] = '{1, 0, 3'd6, 8'h00, 4'd0, codes4(0, 0, 0, 0),               8'hEE, STS_TMO, 4'd0, 8'd17};
      vt[4] = '{0, 0, 3'd1, 8'h00, 4'd1, codes4(C_AE, 0, 0, 0),            8'h77, STS_OK,  4'd0, 8'd3};
      vt[5] = '{1, 1, 3'd4, 8'hC3, 4'd1, codes4(C_ERR, 0, 0, 0),           8'h00, STS_ERR, 4'd0, 8'd3};
      vt[6] = '{0, 0, 3'd7, 8'h00, 4'd2, codes4(C_RTY, C_ERR, 0, 0),       8'h99, STS_ERR, 4'd1, 8'd5};
      vt[7] = '{1, 0, 3'd0, 8'h00, 4'd1, codes4(C_ACK, 0, 0, 0),           8'hE1, STS_OK,  4'd0, 8'd3};

      do_reset();

      // Simultaneous reads straight after reset: r0 wins the first tie
      resp_q.push_back('{code: C_ACK, data: 8'h11});
      resp_q.push_back('{code: C_ACK, data: 8'h3C});
      sb.push_back('{rq: 1'b0, sts: STS_OK, dat: 8'h11, upd: 1'b1});
      sb.push_back('{rq: 1'b1, sts: STS_OK, dat: 8'h3C, upd: 1'b1});
      @(posedge clk); #1;
      r0_req = 1; r0_we = 0; r0_adr = 3'd1;
      r1_req = 1; r1_we = 0; r1_adr = 3'd6;
      n = 0;
      for (int c = 0; c < 40 && n < 2; c++) begin
         @(negedge clk);
         if (r0_done_o) begin r0_req = 0; n++; end
         if (r1_done_o) begin r1_req = 0; n++; end
      end
      r0_req = 0; r1_req = 0;
      chk("both served", n, 2);
      chk("r1 read 3C", r1_dat_o, 8'h3C);

      for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // Reset asserted mid-BUS: cyc/stb drop at once and no done follows
      do_reset();
      @(posedge clk); #1;
      r0_req = 1; r0_we = 0; r0_adr = 3'd2;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (wb_cyc_o) got = 1;
      end
      chk("cyc before reset", {31'd0, wb_cyc_o}, 1);
      @(posedge clk); #2;
      rst_n = 0;
      #1;
      chk("cyc/stb async drop", {30'd0, wb_cyc_o, wb_stb_o}, 0);
      r0_req = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      chk("no done after reset", {30'd0, r0_done_o, r1_done_o}, 0);
      chk("r0 sts after reset", r0_sts_o, STS_OK);

`ifdef I2C_SPI_SCHED_STATS_EN
      do_reset();
      chk("stat reset", {stat_err_o, stat_rty_o}, 0);
      run_vec('{0, 0, 3'd1, 8'h00, 4'd3, codes4(C_RTY, C_RTY, C_ERR, 0), 8'h00, STS_ERR, 4'd2, 8'd7}, "stat mix");
      chk("stat_rty 2", stat_rty_o, 8'd2);
      chk("stat_err 1", stat_err_o, 8'd1);
      for (int i = 0; i < 300; i++)
         run_vec('{i[0], 1, 3'd4, 8'h00, 4'd1, codes4(C_ERR, 0, 0, 0), 8'h00, STS_ERR, 4'd0, 8'd3}, "stat err");
      chk("stat_err saturate", stat_err_o, 8'd255);
      chk("stat_rty after errs", stat_rty_o, 8'd2);
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
